// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
//
// Upstream feeder for the serial sequence detector. Parallel words arrive
// over a valid/ready handshake and leave one bit per clock on x, which is
// wired straight to the detector's x input. A one-word holding buffer lets
// consecutive words stream out with no idle bits between them.
//
// All registers update on the rising edge of clk. The detector samples on
// the falling edge, so x has half a clock period of setup time.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level driven on x when no frame is being shifted
//
// Ports:
//   clk          clock, rising edge
//   clr          asynchronous reset, active low
//   din          parallel data word
//   din_valid    din is valid this cycle
//   din_ready    a word can be accepted (transfer when valid & ready)
//   x            serial bit stream to the detector
//   bit_valid    x carries a data bit this cycle
//   frame_start  x carries the first bit of a word
//   frame_end    x carries the last bit of a word
//   busy         shift register or holding buffer occupied
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
   parameter int   WIDTH     = 8,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;

   logic             accept;
   logic             head;
   logic [WIDTH-1:0] shifted;

   // The ready flag depends only on registered state (plus the reset pin,
   // which forces it low while clr is asserted), so there is never a
   // combinational loop through the upstream valid logic.
   assign din_ready = clr & ~hold_full;
   assign accept    = din_valid & din_ready;

   // Head bit and the next shift-register value depend on bit order. The
   // shift always moves the next bit into the head position.
   assign head    = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
   assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

   // Outputs are decoded from registered state only, so din never reaches x
   // combinationally and x drops to the idle level as soon as reset clears
   // the state register.
   assign x           = (state == SHIFT) ? head : IDLE_BIT;
   assign bit_valid   = (state == SHIFT);
   assign frame_start = (state == SHIFT) && (cnt == CNT_MAX);
   assign frame_end   = (state == SHIFT) && (cnt == '0);
   assign busy        = (state == SHIFT) || hold_full;

   // Main sequencer. In IDLE an accepted word goes straight into the shift
   // register. While shifting, an accepted word parks in the holding buffer.
   // On the last bit of a frame the next word comes from the holding buffer
   // first (it is older), otherwise from din directly if one is accepted
   // on that very edge, so back-to-back words never leave an idle gap.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= din;
                  cnt   <= CNT_MAX;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  shreg <= shifted;
                  cnt   <= cnt - CNT_ONE;
                  if (accept) begin
                     hold      <= din;
                     hold_full <= 1'b1;
                  end
               end else if (hold_full) begin
                  shreg <= hold;
                  cnt   <= CNT_MAX;
                  if (accept) begin
                     hold      <= din;
                     hold_full <= 1'b1;
                  end else begin
                     hold_full <= 1'b0;
                  end
               end else if (accept) begin
                  shreg <= din;
                  cnt   <= CNT_MAX;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Directed bench for seq_bit_serializer. One instance runs MSB-first and a
// second runs LSB-first; both share clock and reset. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge, half a
// cycle away from the rising edge where the design updates.
// ---------------------------------------------------------------------------
module tb_seq_bit_serializer;

   logic       clk;
   logic       clr;

   logic [7:0] dinA;
   logic       validA;
   logic       readyA;
   logic       xA;
   logic       bitValidA;
   logic       frameStartA;
   logic       frameEndA;
   logic       busyA;

   logic [7:0] dinB;
   logic       validB;
   logic       readyB;
   logic       xB;
   logic       bitValidB;
   logic       frameStartB;
   logic       frameEndB;
   logic       busyB;

   int errors = 0;
   int checks = 0;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
      .clk         (clk),
      .clr         (clr),
      .din         (dinA),
      .din_valid   (validA),
      .din_ready   (readyA),
      .x           (xA),
      .bit_valid   (bitValidA),
      .frame_start (frameStartA),
      .frame_end   (frameEndA),
      .busy        (busyA)
   );

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dutLsb (
      .clk         (clk),
      .clr         (clr),
      .din         (dinB),
      .din_valid   (validB),
      .din_ready   (readyB),
      .x           (xB),
      .bit_valid   (bitValidB),
      .frame_start (frameStartB),
      .frame_end   (frameEndB),
      .busy        (busyB)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time expired, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present one word to the MSB-first instance for a single accepting edge.
   // Returns on the falling edge where the first bit is on x.
   task automatic applyStimulus(input logic [7:0] word);
      @(negedge clk);
      dinA   = word;
      validA = 1'b1;
      @(negedge clk);
      validA = 1'b0;
   endtask

   // Same as applyStimulus, for the LSB-first instance.
   task automatic applyStimulusLsb(input logic [7:0] word);
      @(negedge clk);
      dinB   = word;
      validB = 1'b1;
      @(negedge clk);
      validB = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (xA !== 1'b0) begin errors++; $display("[TB] FAIL reset_x: got %b expected 0", xA); end
      checks++;
      if ({bitValidA, frameStartA, frameEndA, busyA} !== 4'b0000) begin
         errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bitValidA, frameStartA, frameEndA, busyA});
      end
      checks++;
      if ({readyA, readyB} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {readyA, readyB}); end
      clr = 1'b1;
      #1;
      checks++;
      if ({readyA, readyB} !== 2'b11) begin errors++; $display("[TB] FAIL release_ready: got %b expected 11", {readyA, readyB}); end
   endtask

   task automatic test_msb_single();
      logic [7:0] got;
      got = '0;
      applyStimulus(8'hA5);
      for (int i = 0; i < 8; i++) begin
         got[7-i] = xA;
         checks++;
         if (bitValidA !== 1'b1) begin errors++; $display("[TB] FAIL msb_bit_valid[%0d]: got %b expected 1", i, bitValidA); end
         checks++;
         if (frameStartA !== ((i == 0) ? 1'b1 : 1'b0)) begin
            errors++; $display("[TB] FAIL msb_frame_start[%0d]: got %b expected %b", i, frameStartA, (i == 0));
         end
         checks++;
         if (frameEndA !== ((i == 7) ? 1'b1 : 1'b0)) begin
            errors++; $display("[TB] FAIL msb_frame_end[%0d]: got %b expected %b", i, frameEndA, (i == 7));
         end
         @(negedge clk);
      end
      checks++;
      if (got !== 8'b1010_0101) begin errors++; $display("[TB] FAIL msb_bits: got %b expected 10100101", got); end
      checks++;
      if ({xA, busyA, bitValidA} !== 3'b000) begin
         errors++; $display("[TB] FAIL msb_after_frame: got x/busy/valid %b expected 000", {xA, busyA, bitValidA});
      end
   endtask

   task automatic test_lsb_word(input logic [7:0] word, input logic [7:0] expected, input string name);
      logic [7:0] got;
      int         validCycles;
      got         = '0;
      validCycles = 0;
      applyStimulusLsb(word);
      for (int i = 0; i < 8; i++) begin
         got[7-i] = xB;
         if (bitValidB === 1'b1) validCycles++;
         @(negedge clk);
      end
      checks++;
      if (got !== expected) begin errors++; $display("[TB] FAIL %s_bits: got %b expected %b", name, got, expected); end
      checks++;
      if (validCycles != 8 || bitValidB !== 1'b0 || xB !== 1'b0) begin
         errors++; $display("[TB] FAIL %s_frame: got %0d valid cycles, trailing valid %b x %b, expected 8,0,0", name, validCycles, bitValidB, xB);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] words;
      logic [23:0] stream;
      int          idx;
      int          nBits;
      int          nStart;
      int          nEnd;
      logic        willAccept;
      logic        started;
      logic        ended;
      logic        gap;
      logic        sawLow;
      logic        sawRecover;
      words = 24'h112233;
      stream = '0;
      nBits = 0; nStart = 0; nEnd = 0;
      started = 1'b0; ended = 1'b0; gap = 1'b0; sawLow = 1'b0; sawRecover = 1'b0;
      @(negedge clk);
      idx        = 0;
      dinA       = words[23 -: 8];
      validA     = 1'b1;
      willAccept = readyA;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bitValidA === 1'b1) begin
            if (ended) gap = 1'b1;
            started = 1'b1;
            stream  = {stream[22:0], xA};
            nBits++;
            if (frameStartA === 1'b1) nStart++;
            if (frameEndA === 1'b1) nEnd++;
         end else if (started) begin
            ended = 1'b1;
         end
         if (readyA === 1'b0 && validA) sawLow = 1'b1;
         if (readyA === 1'b1 && sawLow) sawRecover = 1'b1;
         if (willAccept) idx++;
         if (idx < 3) begin
            dinA   = words[23 - 8*idx -: 8];
            validA = 1'b1;
         end else begin
            validA = 1'b0;
         end
         willAccept = validA && (readyA === 1'b1);
      end
      validA = 1'b0;
      checks++;
      if (nBits != 24) begin errors++; $display("[TB] FAIL b2b_bit_count: got %0d expected 24", nBits); end
      checks++;
      if (gap !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got gap %b expected 0", gap); end
      checks++;
      if (stream !== 24'h112233) begin errors++; $display("[TB] FAIL b2b_order: got %h expected 112233", stream); end
      checks++;
      if (nStart != 3 || nEnd != 3) begin errors++; $display("[TB] FAIL b2b_frames: got start %0d end %0d expected 3 3", nStart, nEnd); end
      checks++;
      if ({sawLow, sawRecover} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_ready: got low/recover %b expected 11", {sawLow, sawRecover}); end
   endtask

   task automatic test_bypass();
      logic [15:0] stream;
      logic        sentSecond;
      stream     = '0;
      sentSecond = 1'b0;
      applyStimulus(8'hC3);
      for (int i = 0; i < 16; i++) begin
         stream = {stream[14:0], xA};
         if (i == 8) begin
            checks++;
            if (frameStartA !== 1'b1) begin errors++; $display("[TB] FAIL bypass_frame_start: got %b expected 1", frameStartA); end
            checks++;
            if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL bypass_hold_empty: got ready %b expected 1", readyA); end
         end
         if (frameEndA === 1'b1 && !sentSecond) begin
            dinA       = 8'h3C;
            validA     = 1'b1;
            sentSecond = 1'b1;
         end else begin
            validA = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (stream !== 16'hC33C) begin errors++; $display("[TB] FAIL bypass_bits: got %h expected c33c", stream); end
      checks++;
      if (bitValidA !== 1'b0) begin errors++; $display("[TB] FAIL bypass_end: got valid %b expected 0", bitValidA); end
   endtask

   task automatic test_reset_mid_frame();
      int leftover;
      applyStimulus(8'hFF);
      dinA   = 8'h0F;
      validA = 1'b1;
      @(negedge clk);
      validA = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({xA, busyA, readyA} !== 3'b110) begin
         errors++; $display("[TB] FAIL midreset_before: got x/busy/ready %b expected 110", {xA, busyA, readyA});
      end
      clr = 1'b0;
      #1;
      checks++;
      if ({xA, busyA, bitValidA, readyA} !== 4'b0000) begin
         errors++; $display("[TB] FAIL midreset_async: got x/busy/valid/ready %b expected 0000", {xA, busyA, bitValidA, readyA});
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      #1;
      checks++;
      if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", readyA); end
      leftover = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bitValidA !== 1'b0 || xA !== 1'b0 || busyA !== 1'b0) leftover++;
      end
      checks++;
      if (leftover != 0) begin errors++; $display("[TB] FAIL midreset_residual: got %0d active cycles expected 0", leftover); end
   endtask

   task automatic test_detector_link();
      logic [7:0] xs;
      logic [7:0] ys;
      logic       prevBit;
      logic       curBit;
      xs      = '0;
      ys      = '0;
      prevBit = xA;
      applyStimulus(8'b1000_0000);
      for (int i = 0; i < 8; i++) begin
         curBit   = xA;
         xs[7-i]  = curBit;
         ys[7-i]  = ({prevBit, curBit} == 2'b00) || ({prevBit, curBit} == 2'b10);
         prevBit  = curBit;
         @(negedge clk);
      end
      checks++;
      if (xs !== 8'b1000_0000) begin errors++; $display("[TB] FAIL link_x: got %b expected 10000000", xs); end
      checks++;
      if (ys !== 8'b0111_1111) begin errors++; $display("[TB] FAIL link_y: got %b expected 01111111", ys); end
   endtask

   // Scenario sequence: each task leaves both instances idle for the next.
   initial begin
      clr    = 1'b0;
      dinA   = '0;
      validA = 1'b0;
      dinB   = '0;
      validB = 1'b0;
      test_reset();
      test_msb_single();
      test_lsb_word(8'hA5, 8'b1010_0101, "lsb_a5");
      test_lsb_word(8'h01, 8'b1000_0000, "lsb_01");
      test_back_to_back();
      repeat (2) @(negedge clk);
      test_bypass();
      test_reset_mid_frame();
      test_detector_link();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `x`, which connects directly to the detector's `x` input.
- Includes a one-word holding buffer, so consecutive words stream with no idle bits between them.
- Register updates occur on posedge `clk`. Because the detector samples on negedge `clk`, `x` has half a cycle of setup time.

Parameters:
- WIDTH, 8, bits per word; must be at least 2.
- MSB_FIRST, 1, 1 means bit WIDTH-1 is sent first; 0 means bit 0 is sent first.
- IDLE_BIT, 0, value driven on `x` when no frame is being shifted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel data word.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  block can accept a word; a transfer occurs on a rising edge where `din_valid` and `din_ready` are both 1.
- x  output  1  serial bit stream to the detector.
- bit_valid  output  1  `x` carries a data bit this cycle.
- frame_start  output  1  `x` carries the first bit of a word.
- frame_end  output  1  `x` carries the last bit of a word.
- busy  output  1  shift register or holding buffer is occupied.

Behaviour:
- Storage:
  - `shreg[WIDTH-1:0]`.
  - `cnt`, $clog2(WIDTH) bits: the number of bits remaining after the current bit.
  - `hold[WIDTH-1:0]` with flag `hold_full`.
  - State register: IDLE or SHIFT.
- Reset (`clr` = 0, asynchronous):
  - state = IDLE, `hold_full` = 0, `shreg` = 0, `cnt` = 0.
  - Outputs: `x` = IDLE_BIT, `bit_valid` = 0, `frame_start` = 0, `frame_end` = 0, `busy` = 0, `din_ready` = 0.
  - `din_ready` is forced to 0 while `clr` is low and becomes 1 in the first cycle after release.
- din_ready: equals `~hold_full` when out of reset.
- Shift-register free condition: `load_ok` = (state == IDLE) or (state == SHIFT and `cnt` == 0).
- IDLE:
  - `x` = IDLE_BIT; `bit_valid`, `frame_start` and `frame_end` are all 0.
  - On accept: `shreg` <= `din`, `cnt` <= WIDTH-1, state <= SHIFT.
  - The first bit of the word appears on `x` in the next cycle, so input-to-output latency is 1 cycle.
- SHIFT:
  - `x` is the current head bit: `shreg[WIDTH-1]` when MSB_FIRST=1, else `shreg[0]`.
  - `bit_valid` = 1.
  - `frame_start` = (`cnt` == WIDTH-1).
  - `frame_end` = (`cnt` == 0).
  - While `cnt` > 0: `shreg` shifts toward the head (left when MSB_FIRST=1, right otherwise), `cnt` decrements, and any accepted word is written to `hold`, setting `hold_full`.
  - At `cnt` == 0 (last bit), apply the first matching rule:
    - `hold_full`: `shreg` <= `hold`, `hold_full` <= 0, `cnt` <= WIDTH-1, stay in SHIFT. Any word accepted this same cycle is written to `hold` and `hold_full` stays 1.
    - Otherwise, if a word is accepted this cycle: `shreg` <= `din`, `cnt` <= WIDTH-1, stay in SHIFT. This path bypasses `hold`.
    - Otherwise: state <= IDLE.
  - Result: back-to-back words produce contiguous bits, and `frame_start` immediately follows `frame_end`.
- Holding-buffer ordering:
  - Words always leave in acceptance order.
  - A word is never written to `hold` while `hold_full` = 1, because `din_ready` is 0 then.
- busy: (state == SHIFT) or `hold_full`.
- din stability: `din` and `din_valid` are sampled only at the accepting edge. When `din_ready` = 0, `din_valid` may remain high; it has no effect and no data is lost.
- Reset mid-frame: the in-flight word and the held word are discarded. `x` returns to IDLE_BIT asynchronously. No partial frame resumes after reset.
- Implementation: `cnt` and all state are pure counters/registers; no combinational path exists from `din` to `x`.

Test Plan:
- WIDTH=8, MSB_FIRST=1, `din` = 8'hA5 pulsed valid for one cycle:
  - `x` = 1,0,1,0,0,1,0,1 over cycles 1–8 after accept.
  - `frame_start` in cycle 1, `frame_end` in cycle 8, then `x` = 0 and `busy` = 0.
- MSB_FIRST=0, `din` = 8'hA5: `x` = 1,0,1,0,0,1,0,1 (LSB first; this value is a palindrome). Repeat with 8'h01: `x` = 1,0,0,0,0,0,0,0.
- `din_valid` held high with words 8'h11, 8'h22, 8'h33:
  - 24 contiguous `bit_valid` cycles with no gap; output order 11, 22, 33.
  - `din_ready` drops to 0 after `hold` fills and rises once `hold` loads into `shreg`.
- Word accepted exactly on the `frame_end` cycle with `hold` empty: the next word starts in the following cycle via the bypass path, and `hold_full` stays 0.
- Reset mid-frame: assert `clr` at the 4th bit of 8'hFF while `hold` contains 8'h0F:
  - `x` = IDLE_BIT immediately and `busy` = 0.
  - After release, `din_ready` = 1 and no residual bits are emitted.
- Integration with the detector: stream 8'b1000_0000 (MSB_FIRST=1) into the detector. The detector's `y` follows its 00/10 last-two-bit rule; check `y` against a reference model at each negedge.
